// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing generator.
// Produces a pixel clock-enable (p_tick) from the system clock, the pixel
// coordinates (x, y), active-low hsync/vsync, video_on and a one-clk
// frame_start pulse at every wrap to (0,0). All outputs come straight from flops.
// Optional feature: define VGA_SYNC_FRAMECNT_EN to add the 8-bit frame_count port.
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
`ifdef VGA_SYNC_FRAMECNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Divider width; a divide-by-1 still gets a 1-bit counter that stays at 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             p_tick_q, p_tick_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             frame_start_q, frame_start_d;

  // Next-state: divider, tick, counters, and sync/blank decoded from the next counts.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    div_d         = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    p_tick_d      = (div_q == DIV_LAST);
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;

    if (p_tick_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end

    // Decoding the next counts keeps sync/blank aligned with the x/y they describe.
    hsync_d    = !((x_d >= HS_START) && (x_d <= HS_END));
    vsync_d    = !((y_d >= VS_START) && (y_d <= VS_END));
    video_on_d = (x_d < H_VIS) && (y_d < V_VIS);
  end

  // State and output registers; reset leaves the raster parked at (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q         <= '0;
      p_tick_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      div_q         <= div_d;
      p_tick_q      <= p_tick_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign p_tick      = p_tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAMECNT_EN
  logic [7:0] frame_count_q;

  // Frame counter steps on the same edge that raises frame_start; wraps naturally at 255.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (frame_start_d) begin
      frame_count_q <= frame_count_q + 1'b1;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Free-running VGA timing generator producing horizontal/vertical sync, blanking, and the 10-bit pixel coordinates (x, y) consumed by the pattern and pixel-colour logic. Default geometry is 640x480 @ 60 Hz, with the 25 MHz pixel rate derived from the system clock by an internal clock-enable divider. Sits between the board clock/reset and every coordinate-driven pixel generator in the VGA system.

## Interface
- CLK_DIV, 4, system clocks per pixel; integer ≥ 1; 4 gives 25 MHz from 100 MHz.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BACK, 48, horizontal back porch, in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BACK, 33, vertical back porch, in lines.
- clk  input  1  system clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- p_tick  output  1  pixel clock enable; one clk pulse every CLK_DIV clks.
- x  output  10  horizontal count, 0 to H_TOTAL-1.
- y  output  10  vertical count, 0 to V_TOTAL-1.
- hsync  output  1  horizontal sync, active-low.
- vsync  output  1  vertical sync, active-low.
- video_on  output  1  high when x < H_DISPLAY and y < V_DISPLAY.
- frame_start  output  1  one-clk pulse when the counters wrap to (0,0).
- frame_count  output  8  frame counter; present only with VGA_SYNC_FRAMECNT_EN.

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL likewise (default 525). Both must be ≤ 1024.
- Divider: counter 0..CLK_DIV-1. p_tick is registered and is high for the clk in which the divider equals CLK_DIV-1. With CLK_DIV=1, p_tick is constantly high after reset.
- On each clk edge with p_tick high, x increments. When x = H_TOTAL-1, x wraps to 0 and y increments. When y = V_TOTAL-1 at the same time, y also wraps to 0.
- hsync is low exactly when x is in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1] (default [656, 751]).
- vsync is low exactly when y is in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1] (default [490, 491]).
- hsync, vsync and video_on are registered. They are computed from the next-count values, so each is coincident with the x/y it describes, with no pipeline skew.
- frame_start is high for one clk: the clk following the edge at which (x, y) became (0,0) through wrap-around. It is not asserted on reset release.
- Outputs never glitch; every output is a flop.
- Reset values: divider=0, p_tick=0, x=0, y=0, hsync=1, vsync=1, video_on=1, frame_start=0, frame_count=0.
- Reset asserted mid-frame immediately forces all reset values. Counting restarts from (0,0), with the first p_tick CLK_DIV clks after deassertion.

## Timing
- Counter update latency: x/y change on the clk edge at which p_tick is sampled high.
- Pixel period is CLK_DIV clks. Line period is H_TOTAL×CLK_DIV clks (3200 by default). Frame period is H_TOTAL×V_TOTAL×CLK_DIV clks (1,680,000 by default).
- Between pixel ticks, x, y, hsync, vsync and video_on are held constant.

## Configuration
- VGA_SYNC_FRAMECNT_EN defined: the frame_count port exists as an 8-bit counter. It increments in the same clk that frame_start is asserted and wraps from 255 to 0. Reset value is 0.
- VGA_SYNC_FRAMECNT_EN undefined: the frame_count port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset then release, CLK_DIV=4 -> p_tick first high 4 clks after release, then every 4th clk; x=1 after the first tick.
- Run one line -> hsync low for exactly 96 ticks starting at x=656. video_on falls at x=640. x wraps 799→0 and y increments 0→1 on the same edge.
- Run one full frame -> vsync low for y=490..491 (1600 ticks). y wraps 524→0. frame_start pulses once, 1,680,000 clks after reset release.
- Assert reset at x=300, y=200 -> all outputs take their reset values without waiting for a clk edge. Counting resumes from (0,0) after release.
- CLK_DIV=1 -> p_tick constantly high; frame period is 420,000 clks.
- With VGA_SYNC_FRAMECNT_EN, run 257 frames -> frame_count reads 1 after the 257th frame_start, confirming wrap at 255.
